updown_mod_counter: RTL and testbench

- Parametrised up/down counter with programmable modulus, step size, synchronous load and selectable wrap or saturate mode.
- Successor to the plain fixed-width up/down counter. Used as the general-purpose counting primitive for timers, pointers and rate dividers.
- Fully registered count and event flags; status flags are combinational from the count.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_next_calc.sv | 63 ++++++
 rtl/updown_mod_counter.sv | 77 +++++++
 tb/tb_updown_mod_counter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for counting primitives (counters,
// pointers, timers).
//   cnt_mode_e : overflow policy, modular wrap or clip at the bound.
//   cnt_ext_w  : width of the working arithmetic for a W-bit count. It is
//                one bit wider so that cnt+step and max_val+1 never alias.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    function automatic int cnt_ext_w(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// counter_next_calc: combinational next-count evaluation for one enabled step.
//   cnt, step, max_val : current count, increment and upper bound (W bits)
//   up                 : 1 = count up, 0 = count down
//   next               : candidate count after the step
//   wrap               : the step wrapped (CNT_WRAP) or clipped (CNT_SAT)
//   err                : the step was rejected because step > max_val
// The caller must apply these outputs only when en is set and load is clear.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int        W    = 8,
    parameter cnt_mode_e MODE = CNT_WRAP
) (
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] step,
    input  logic [W-1:0] max_val,
    input  logic         up,
    output logic [W-1:0] next,
    output logic         wrap,
    output logic         err
);

    localparam int XW = cnt_ext_w(W);

    logic [XW-1:0] c, s, m, modulus, sum, nx;

    always_comb begin
        c       = {1'b0, cnt};
        s       = {1'b0, step};
        m       = {1'b0, max_val};
        modulus = m + 1'b1;
        sum     = c + s;
        nx      = c;
        wrap    = 1'b0;
        err     = 1'b0;
        if (s > m) begin
            err = 1'b1;
        end else if (s == '0) begin
            nx = c;
        end else if (c > m) begin
            // max_val was lowered below the current count: snap back into range
            nx   = (MODE == CNT_SAT) ? m : '0;
            wrap = 1'b1;
        end else if (up) begin
            if (sum > m) begin
                nx   = (MODE == CNT_SAT) ? m : sum - modulus;
                wrap = 1'b1;
            end else begin
                nx = sum;
            end
        end else begin
            if (s > c) begin
                // c + modulus - s stays below 2*modulus, so XW bits suffice
                nx   = (MODE == CNT_SAT) ? '0 : c + modulus - s;
                wrap = 1'b1;
            end else begin
                nx = c - s;
            end
        end
        next = nx[W-1:0];
    end

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down counter with programmable modulus, step size,
// synchronous load and a wrap or saturate overflow policy.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   en, up    : step enable and direction
//   step      : increment per enabled cycle
//   max_val   : upper bound, count range is 0..max_val
//   load      : load strobe, loads min(load_val, max_val)
//   cnt       : registered count
//   at_max    : cnt == max_val (combinational)
//   at_zero   : cnt == 0 (combinational)
//   wrap      : registered pulse, last update wrapped or clipped
//   step_err  : registered pulse, last enabled step was rejected
// Priority on each edge: rst, then load, then en.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int        W       = 8,
    parameter cnt_mode_e MODE    = CNT_WRAP,
    parameter int        RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] step,
    input  logic [W-1:0] max_val,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         at_max,
    output logic         at_zero,
    output logic         wrap,
    output logic         step_err
);

    localparam logic [W-1:0] RST_CNT = W'(RST_VAL);

    logic [W-1:0] nxt;
    logic         nxt_wrap;
    logic         nxt_err;

    counter_next_calc #(
        .W    (W),
        .MODE (MODE)
    ) u_next (
        .cnt     (cnt),
        .step    (step),
        .max_val (max_val),
        .up      (up),
        .next    (nxt),
        .wrap    (nxt_wrap),
        .err     (nxt_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= RST_CNT;
            wrap     <= 1'b0;
            step_err <= 1'b0;
        end else if (load) begin
            cnt      <= (load_val > max_val) ? max_val : load_val;
            wrap     <= 1'b0;
            step_err <= 1'b0;
        end else if (en) begin
            cnt      <= nxt;
            wrap     <= nxt_wrap;
            step_err <= nxt_err;
        end else begin
            wrap     <= 1'b0;
            step_err <= 1'b0;
        end
    end

    assign at_max  = (cnt == max_val);
    assign at_zero = (cnt == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: a wrap-mode and a saturate-mode instance
// share one set of inputs. An integer-arithmetic model tracks both and is
// compared on every falling edge; directed sequences also pin literal values.
module tb_updown_mod_counter;
    import counter_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0, up = 1'b1, load = 1'b0;
    logic [W-1:0] step = '0, max_val = 8'd9, load_val = '0;

    logic [W-1:0] cnt   [2];
    logic         amax  [2];
    logic         azero [2];
    logic         wrp   [2];
    logic         serr  [2];

    always #5 clk = ~clk;

    updown_mod_counter #(.W(W), .MODE(CNT_WRAP), .RST_VAL(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .max_val(max_val),
        .load(load), .load_val(load_val), .cnt(cnt[0]), .at_max(amax[0]),
        .at_zero(azero[0]), .wrap(wrp[0]), .step_err(serr[0]));

    updown_mod_counter #(.W(W), .MODE(CNT_SAT), .RST_VAL(0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .max_val(max_val),
        .load(load), .load_val(load_val), .cnt(cnt[1]), .at_max(amax[1]),
        .at_zero(azero[1]), .wrap(wrp[1]), .step_err(serr[1]));

    // ---------------- behavioural model ----------------
    int mcnt [2];
    bit mwrap [2];
    bit merr [2];
    bit mvalid = 0;

    always @(posedge clk) begin
        int c, mx, st;
        bit w, e;
        mx = int'(max_val);
        st = int'(step);
        for (int k = 0; k < 2; k++) begin
            c = mcnt[k]; w = 0; e = 0;
            if (rst) c = 0;
            else if (load) c = (int'(load_val) < mx) ? int'(load_val) : mx;
            else if (en) begin
                if (st > mx) e = 1;
                else if (st == 0) c = c;
                else if (c > mx) begin c = (k == 1) ? mx : 0; w = 1; end
                else if (up) begin
                    if (c + st > mx) begin c = (k == 1) ? mx : c + st - (mx + 1); w = 1; end
                    else c = c + st;
                end else begin
                    if (st > c) begin c = (k == 1) ? 0 : c + (mx + 1) - st; w = 1; end
                    else c = c - st;
                end
            end
            mcnt[k] <= c; mwrap[k] <= w; merr[k] <= e;
        end
        if (rst) mvalid <= 1;
    end

    // ---------------- literal expectations (written by stimulus only) ----------------
    bit lit_en = 0;
    int lit_idx, lit_cnt;
    bit lit_wrap, lit_err;

    // ---------------- compare process ----------------
    int ncmp = 0, nerr = 0;

    always @(negedge clk) begin
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                ncmp++;
                if (int'(cnt[k]) != mcnt[k] || amax[k] != (mcnt[k] == int'(max_val)) ||
                    azero[k] != (mcnt[k] == 0) || wrp[k] != mwrap[k] || serr[k] != merr[k]) begin
                    nerr++;
                    $display("FAIL model[%0d] t=%0t: got cnt=%0d at_max=%b at_zero=%b wrap=%b err=%b, want cnt=%0d at_max=%b at_zero=%b wrap=%b err=%b",
                             k, $time, cnt[k], amax[k], azero[k], wrp[k], serr[k],
                             mcnt[k], mcnt[k] == int'(max_val), mcnt[k] == 0, mwrap[k], merr[k]);
                end
            end
        end
        if (lit_en) begin
            ncmp++;
            if (int'(cnt[lit_idx]) != lit_cnt || wrp[lit_idx] != lit_wrap || serr[lit_idx] != lit_err) begin
                nerr++;
                $display("FAIL literal[%0d] t=%0t: got cnt=%0d wrap=%b err=%b, want cnt=%0d wrap=%b err=%b",
                         lit_idx, $time, cnt[lit_idx], wrp[lit_idx], serr[lit_idx], lit_cnt, lit_wrap, lit_err);
            end
            if (lit_cnt == int'(max_val)) begin
                ncmp++;
                if (!amax[lit_idx]) begin
                    nerr++;
                    $display("FAIL literal_at_max[%0d] t=%0t: got %b want 1", lit_idx, $time, amax[lit_idx]);
                end
            end
            if (lit_cnt == 0) begin
                ncmp++;
                if (!azero[lit_idx]) begin
                    nerr++;
                    $display("FAIL literal_at_zero[%0d] t=%0t: got %b want 1", lit_idx, $time, azero[lit_idx]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        lit_en = 0;
    endtask

    task automatic expect_lit(input int idx, input int c, input bit w, input bit e);
        lit_idx = idx; lit_cnt = c; lit_wrap = w; lit_err = e; lit_en = 1;
    endtask

    initial begin
        int exp_c;
        // reset and hold
        rst = 1; cyc(); cyc();
        rst = 0; en = 0;
        for (int i = 0; i < 5; i++) begin cyc(); expect_lit(0, 0, 0, 0); end
        cyc();
        // count to 7, then reset mid-count
        max_val = 9; step = 1; up = 1; en = 1;
        for (int i = 0; i < 7; i++) cyc();
        expect_lit(0, 7, 0, 0);
        rst = 1; cyc(); expect_lit(0, 0, 0, 0);
        // wrap up 0..9,0,1,2
        rst = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            exp_c = i % 10;
            expect_lit(0, exp_c, exp_c == 0, 0);
        end
        // wrap down with step 3 from 1
        en = 0; load = 1; load_val = 1; cyc(); expect_lit(0, 1, 0, 0);
        load = 0; en = 1; up = 0; step = 3;
        cyc(); expect_lit(0, 8, 1, 0);
        cyc(); expect_lit(0, 5, 0, 0);
        cyc(); expect_lit(0, 2, 0, 0);
        cyc(); expect_lit(0, 9, 1, 0);
        // saturate
        max_val = 200; step = 50; load = 1; load_val = 180; up = 1; cyc(); expect_lit(1, 180, 0, 0);
        load = 0;
        cyc(); expect_lit(1, 200, 1, 0);
        cyc(); expect_lit(1, 200, 1, 0);
        up = 0;
        cyc(); expect_lit(1, 150, 0, 0);
        // load priority and clamp, then lowered bound
        max_val = 100; load = 1; load_val = 250; en = 1; up = 1; step = 1;
        cyc(); expect_lit(0, 100, 0, 0);
        load = 0; max_val = 50; up = 0;
        cyc(); expect_lit(0, 0, 1, 0);
        // saturate instance got the same sequence: clamp to 100, snap to 50
        expect_lit(1, 50, 1, 0);
        #2; lit_en = 0;
        // illegal step
        max_val = 9; load = 1; load_val = 4; cyc(); expect_lit(0, 4, 0, 0);
        load = 0; en = 1; step = 12;
        cyc(); expect_lit(0, 4, 0, 1);
        en = 0;
        cyc(); expect_lit(0, 4, 0, 0);
        en = 1; step = 0;
        cyc(); expect_lit(0, 4, 0, 0);
        // max_val = 0: step 0 legal, step 1 rejected
        max_val = 0; load = 1; load_val = 7; cyc(); expect_lit(0, 0, 0, 0);
        load = 0; step = 1; cyc(); expect_lit(0, 0, 0, 1);
        // full range: 250 + 10 wraps to 4
        max_val = 255; load = 1; load_val = 250; cyc(); expect_lit(0, 250, 0, 0);
        load = 0; up = 1; step = 10; cyc(); expect_lit(0, 4, 1, 0);
        // randomized traffic checked against the model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst  = ($urandom_range(0, 99) == 0);
            load = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) == 1;
            load_val = W'($urandom);
            case ($urandom_range(0, 3))
                0: step = W'($urandom);
                1: step = W'($urandom_range(0, 3));
                default: step = W'($urandom_range(0, 20));
            endcase
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 3))
                    0: max_val = 0;
                    1: max_val = 255;
                    2: max_val = W'($urandom);
                    default: max_val = W'($urandom_range(1, 30));
                endcase
            end
        end
        cyc(); rst = 0; en = 0; load = 0;
        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
